// File: rtl/patch_injector.sv
// patch_injector: replaces RAM read data with patch words on bursts flagged by patch_store.
// Define PATCH_INJECTOR_STATS_EN to build the inject/late counters; otherwise they read 0.
module patch_injector #(
  parameter int LATENCY   = 4,
  parameter int MAX_BURST = 32
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic        ram_clk_i,
  input  logic        ram_ce_n_i,
  input  logic        ram_adv_n_i,
  input  logic        ram_oe_n_i,
  input  logic        ram_we_n_i,
  input  logic        patch_trigger_i,
  input  logic [15:0] patch_data_i,
  output logic        patch_data_next_o,
  output logic [15:0] dq_out_o,
  output logic        dq_oe_o,
  output logic [15:0] inject_count_o,
  output logic [15:0] late_count_o
);
  typedef enum logic [1:0] {IDLE, WAIT, DRIVE} state_t;
  localparam logic [3:0] LAT_T   = 4'(LATENCY - 1);
  localparam logic [7:0] BURST_T = 8'(MAX_BURST);

  state_t      state_q, state_d;
  logic [4:0]  s1_q, s2_q;
  logic        clk3_q;
  logic [3:0]  lat_q, lat_d;
  logic [7:0]  word_q, word_d;
  logic        armed_q, armed_d, oe_q, oe_d, pdn_q, pdn_d;
  logic [15:0] dq_q;
  logic        rise, addr_edge, stop, we_s, inc_inject, no_arm_dec;

  assign rise      = s2_q[4] & ~clk3_q;
  assign addr_edge = rise & ~s2_q[3] & ~s2_q[2];
  assign stop      = s2_q[3] | s2_q[1];
  assign we_s      = s2_q[0];

  always_ff @(posedge mclk or posedge reset)
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      clk3_q  <= 1'b0;
      state_q <= IDLE;
      lat_q   <= '0;
      word_q  <= '0;
      armed_q <= 1'b0;
      oe_q    <= 1'b0;
      pdn_q   <= 1'b0;
      dq_q    <= '0;
    end else begin
      s1_q    <= {ram_clk_i, ram_ce_n_i, ram_adv_n_i, ram_oe_n_i, ram_we_n_i};
      s2_q    <= s1_q;
      clk3_q  <= s2_q[4];
      state_q <= state_d;
      lat_q   <= lat_d;
      word_q  <= word_d;
      armed_q <= armed_d;
      oe_q    <= oe_d;
      pdn_q   <= pdn_d;
      if (state_q != IDLE) dq_q <= patch_data_i;
    end

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    word_d     = word_q;
    armed_d    = armed_q;
    oe_d       = oe_q;
    pdn_d      = 1'b0;
    inc_inject = 1'b0;
    no_arm_dec = 1'b0;
    case (state_q)
      IDLE: if (addr_edge && we_s) begin
        state_d = WAIT;
        lat_d   = '0;
        armed_d = 1'b0;
      end
      WAIT: begin
        armed_d = armed_q | patch_trigger_i;
        if (addr_edge) begin
          state_d = we_s ? WAIT : IDLE;
          lat_d   = '0;
          armed_d = 1'b0;
        end else if (stop) state_d = IDLE;
        else if (rise) begin
          lat_d = lat_q + 4'd1;
          if (lat_q + 4'd1 == LAT_T) begin
            state_d    = armed_d ? DRIVE : IDLE;
            oe_d       = armed_d;
            word_d     = '0;
            inc_inject = armed_d;
            no_arm_dec = ~armed_d;
          end
        end
      end
      DRIVE: begin
        // Every rise in DRIVE is a word the controller samples.
        if (addr_edge) begin
          state_d = we_s ? WAIT : IDLE;
          oe_d    = 1'b0;
          lat_d   = '0;
          armed_d = 1'b0;
        end else if (stop) begin
          state_d = IDLE;
          oe_d    = 1'b0;
        end else if (rise) begin
          pdn_d  = 1'b1;
          word_d = word_q + 8'd1;
          if (word_q + 8'd1 == BURST_T) begin
            state_d = IDLE;
            oe_d    = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign patch_data_next_o = pdn_q;
  assign dq_out_o          = dq_q;
  assign dq_oe_o           = oe_q;

`ifdef PATCH_INJECTOR_STATS_EN
  logic [15:0] inj_q, late_q;
  logic [4:0]  win_q;
  logic        late_inc;

  // A trigger shortly after an unarmed decision, or during DRIVE, came too late to act on.
  assign late_inc = patch_trigger_i && (state_q == DRIVE || (state_q == IDLE && win_q != 5'd0));

  always_ff @(posedge mclk or posedge reset)
    if (reset) begin
      inj_q  <= '0;
      late_q <= '0;
      win_q  <= '0;
    end else begin
      if (inc_inject && inj_q != 16'hFFFF) inj_q <= inj_q + 16'd1;
      if (late_inc && late_q != 16'hFFFF) late_q <= late_q + 16'd1;
      win_q <= no_arm_dec ? 5'd16 : (win_q != 5'd0 ? win_q - 5'd1 : win_q);
    end

  assign inject_count_o = inj_q;
  assign late_count_o   = late_q;
`else
  logic unused_stats;
  assign unused_stats   = ^{inc_inject, no_arm_dec};
  assign inject_count_o = '0;
  assign late_count_o   = '0;
`endif
endmodule

// File: doc/patch_injector.md
# patch_injector

Drives patch data onto the RAM data bus during read bursts that `patch_store` has flagged for patching. It sits directly downstream of `patch_store`: it consumes `patch_trigger` and `patch_data`, and it returns `patch_data_next` once per word the memory controller samples. It tracks the RAM bus itself, using synchronized `ram_clk`, `ce_n`, `adv_n`, `oe_n` and `we_n`. From that it decides, before the first data edge of each read burst, whether to keep the real RAM or to override it with `dq_out`/`dq_oe`.

## Interface
- `LATENCY`, 4, number of `ram_clk` rising edges after the address-latch edge at which the controller samples word 0. Legal range 2..15.
- `MAX_BURST`, 32, maximum number of words driven per burst before forced release. Legal range 1..255.
- `mclk`  in  1  master clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ram_clk`  in  1  raw RAM clock pin, asynchronous to `mclk`.
- `ram_ce_n`, `ram_adv_n`, `ram_oe_n`, `ram_we_n`  in  1 each  raw RAM control pins.
- `patch_trigger`  in  1  one-mclk pulse from `patch_store`: the current burst is patched.
- `patch_data`  in  16  current patch word from `patch_store`.
- `patch_data_next`  out  1  one-mclk pulse: advance to the next patch word.
- `dq_out`  out  16  data driven to the RAM bus.
- `dq_oe`  out  1  output enable for `dq_out`. When it is 1, it overrides the real RAM.
- `inject_count`  out  16  number of bursts patched.
- `late_count`  out  16  number of triggers that arrived after the drive decision.

## Operation
- **Input synchronization.** All five pins pass through 2-flop synchronizers, plus a third `ram_clk` stage for edge detection.
  - `rise` = sync2 && !sync3 on `ram_clk`.
  - `addr_edge` = `rise` && !ce_n && !adv_n, using synchronized values.
- **State machine.** States are IDLE, WAIT, DRIVE. `lat_cnt` is 4 bits and `word_cnt` is 8 bits.
- **IDLE**
  - On `addr_edge` with `we_n`=1: go to WAIT, set `lat_cnt`=0, clear `armed`.
  - On `addr_edge` with `we_n`=0 (write burst): stay in IDLE.
  - `patch_trigger` is ignored.
- **WAIT**
  - `patch_trigger` sets `armed`.
  - Each `rise` increments `lat_cnt`.
  - On the `rise` that makes `lat_cnt` == `LATENCY`-1:
    - If `armed`: go to DRIVE, set `dq_oe`=1, set `word_cnt`=0, increment `inject_count`.
    - Otherwise: return to IDLE (RAM passthrough).
  - `ce_n`=1 or `oe_n`=1 (synchronized) returns to IDLE.
  - A new `addr_edge` restarts WAIT.
- **DRIVE**
  - Each `rise` with `lat_cnt` already at its terminal value is a sampled word:
    - Pulse `patch_data_next` for one mclk.
    - Increment `word_cnt`.
    - On reaching `MAX_BURST`, go to IDLE and clear `dq_oe`.
  - `ce_n`=1 or `oe_n`=1 goes to IDLE and clears `dq_oe`.
  - `addr_edge` goes to WAIT, clears `dq_oe`, and applies the IDLE `addr_edge` rules.
  - `patch_trigger` in DRIVE increments `late_count`. The burst was already committed.
- **Late trigger.** A `patch_trigger` that arrives in IDLE within 16 mclk after a WAIT→IDLE (not armed) decision increments `late_count`. Otherwise it is ignored.
- **Data path.** `dq_out` <= `patch_data` every mclk while in WAIT or DRIVE. `dq_out` holds its value in IDLE.
- **Counters.** Both 16-bit counters saturate at 0xFFFF and never wrap.
- **Simultaneous events.** `addr_edge` and `MAX_BURST` on the same `rise`: `addr_edge` wins and the next state is WAIT.
- **Reset values.** `dq_oe`=0, `dq_out`=0, `patch_data_next`=0, both counters 0, state IDLE, synchronizers 0.
- **Reset mid-burst.** `dq_oe` drops asynchronously.

## Timing
- A pin change first sampled at mclk edge N is acted on at edge N+2. All outputs are registered and change at N+2.
- `dq_oe` rises at N+2 of the (`LATENCY`-1)th post-address `rise`. This is one full `ram_clk` period before the controller samples word 0.
- `patch_data_next` pulses at N+2 of each sampled rise. `patch_store` returns the new word within 2 mclk, and `dq_out` reflects it by N+5.
- Requirement: at least 8 mclk per `ram_clk` half period.
- `patch_trigger` must arrive before the deciding `rise` is processed. With `patch_store`'s pipeline, this holds for `LATENCY` ≥ 3 at the required clock ratio.
- `dq_oe` falls at N+2 of the synchronized `ce_n`/`oe_n` deassertion.

## Configuration
- **`PATCH_INJECTOR_STATS_EN` defined:** `inject_count` and `late_count` are implemented as described above.
- **`PATCH_INJECTOR_STATS_EN` undefined:** both outputs are tied to 16'h0000, their registers are not built, and all other behaviour is identical.

## Test plan
- **Patched read.** `LATENCY`=4, `ram_clk` period 24 mclk. Read burst, trigger 6 mclk after `addr_edge`, `patch_data` increments from 0x1000 per next pulse.
  - `dq_oe`=1 from rise 3.
  - Controller samples 0x1000..0x1007 on rises 4..11.
  - Exactly 8 `patch_data_next` pulses.
  - `inject_count`=1.
- **Unpatched read.** Same burst, no trigger.
  - `dq_oe` stays 0.
  - 0 `patch_data_next` pulses.
  - `inject_count`=0.
- **Write burst.** `we_n`=0, trigger pulsed anyway.
  - `dq_oe` stays 0.
  - State stays IDLE.
- **Early termination and length cap.** `ce_n` rises after 3 words: `dq_oe` falls 2 mclk after the sampled edge, 3 pulses seen. Separately, a 40-word burst with `MAX_BURST`=32: `dq_oe` falls after the 32nd pulse.
- **Late trigger.** Trigger delivered after rise 3 of an unarmed burst: `dq_oe` stays 0 and `late_count`=1. With the macro undefined, `late_count` reads 0.
- **Async reset mid-DRIVE.** `reset` asserted: `dq_oe` drops with no `mclk` edge, all outputs return to 0, and the next burst operates normally.
